// File: rtl/celda_final_der_izq.sv
// Purpose : most-significant cell of a right-to-left magnitude comparator; Z=1 iff A >= B.
// Latency : 0 cycles (combinational), or 1 cycle when CELDA_FINAL_ZREG_EN registers Z.
// Backpressure: none; no handshake, and inputs may change on any cycle.
module celda_final_der_izq (
  input  logic clk,
  input  logic rst_n,
  input  logic p,
  input  logic An_1,
  input  logic Bn_1,
  output logic Z
);

  logic z_d;

  // Differing MSBs decide the result. Equal MSBs pass the chain state p through.
  always_comb begin
    z_d = (An_1 & ~Bn_1) | (~(An_1 ^ Bn_1) & p);
  end

`ifdef CELDA_FINAL_ZREG_EN
  logic z_q;

  // Output register. Reset takes priority over data and clears Z on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z_q <= 1'b0;
    end else begin
      z_q <= z_d;
    end
  end

  assign Z = z_q;
`else
  // The combinational build leaves clk and rst_n without a function.
  // They stay on the port list so that both builds share one interface.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  assign Z = z_d;
`endif

endmodule

// File: tb/tb_celda_final_der_izq.sv
// Bench for celda_final_der_izq in both builds (CELDA_FINAL_ZREG_EN defined or undefined).
// Stimulus pushes the expected Z into a scoreboard. A monitor pops each entry and checks it when it falls due.
// The reference model treats the chain as a 2-bit magnitude compare.
module tb_celda_final_der_izq;

  logic clk;
  logic rst_n;
  logic p;
  logic An_1;
  logic Bn_1;
  logic Z;

  typedef struct {
    int   due;
    logic exp;
    int   tag;
  } sb_item_t;

  sb_item_t sb[$];
  int cyc;
  int checks;
  int failures;

  celda_final_der_izq dut (
    .clk  (clk),
    .rst_n(rst_n),
    .p    (p),
    .An_1 (An_1),
    .Bn_1 (Bn_1),
    .Z    (Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Encode p as the lower-order bits of each word.
  // p=1 gives low A=1, low B=0 (A >= B below the MSB).
  // p=0 gives low A=0, low B=1 (A < B below the MSB).
  // Z is then a plain unsigned compare of the two 2-bit words.
  function automatic logic ref_ge(input logic pp, input logic a, input logic b);
    int wa;
    int wb;
    wa = (a ? 2 : 0) + (pp ? 1 : 0);
    wb = (b ? 2 : 0) + (pp ? 0 : 1);
    return (wa >= wb);
  endfunction

  // Apply one input set for n cycles and push one expectation per cycle.
  task automatic drive(input logic rr, input logic pp, input logic a, input logic b,
                       input int n, input int tag);
    sb_item_t it;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
      rst_n = rr;
      p     = pp;
      An_1  = a;
      Bn_1  = b;
`ifdef CELDA_FINAL_ZREG_EN
      it.due = cyc + 1;
      it.exp = rr ? ref_ge(pp, a, b) : 1'b0;
`else
      it.due = cyc;
      it.exp = ref_ge(pp, a, b);
`endif
      it.tag = tag;
      sb.push_back(it);
    end
  endtask

  // Monitor: on each falling edge, check every expectation that has fallen due.
  initial begin
    sb_item_t it;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        it = sb.pop_front();
        checks = checks + 1;
        if (Z !== it.exp) begin
          failures = failures + 1;
          $display("FAIL z_check tag=%0d cyc=%0d got Z=%b expected %b (p=%b A=%b B=%b rst_n=%b)",
                   it.tag, cyc, Z, it.exp, p, An_1, Bn_1, rst_n);
        end
      end
    end
  end

  initial begin
    int budget;
    logic [3:0] r;
    cyc      = 0;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    p        = 1'b1;
    An_1     = 1'b1;
    Bn_1     = 1'b0;

    // Reset held for 2 edges with p=1, AB=10. Registered Z reads 0; combinational Z reads 1.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2, 1);
    // Release reset with p=1, AB=11.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2, 2);

    // p=1 sweep of AB=00,01,10,11, each held 2 cycles. Then the p=0 sweep.
    for (int pi = 1; pi >= 0; pi--) begin
      for (int ab = 0; ab < 4; ab++) begin
        drive(1'b1, pi[0], ab[1], ab[0], 2, 10 + pi * 4 + ab);
      end
    end

    // p toggles 1->0 with AB=00 held (Z follows p), then with AB=10 held (Z stays 1).
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2, 20);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2, 21);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2, 22);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 2, 23);

    // Reset mid-run while Z=1, then release with p=0, AB=01.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2, 30);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 2, 31);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2, 32);

    // Exhaustive sweep of all 8 (p,A,B) combinations.
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, c[2], c[1], c[0], 2, 40 + c);
    end

    // Random inputs, with occasional reset pulses.
    for (int i = 0; i < 80; i++) begin
      r = 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 7) != 0), r[2], r[1], r[0],
            1 + int'($urandom_range(0, 1)), 100);
    end

    // Let the scoreboard drain within a bounded number of cycles.
    budget = 0;
    while (sb.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    @(negedge clk);
    checks = checks + 1;
    if (sb.size() != 0) begin
      failures = failures + 1;
      $display("FAIL sb_drain pending=%0d required 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
